// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and flattened-bus slice helpers for the register-file write arbiter.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int MAX_REQ    = 8;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Buses are zero-extended to MAX_REQ lanes so one helper serves any NUM_REQ.
    function automatic logic [REG_ADDR_W-1:0] addr_slice(
        input logic [REG_ADDR_W*MAX_REQ-1:0] bus,
        input int i
    );
        return bus[i*REG_ADDR_W +: REG_ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] data_slice(
        input logic [DATA_W*MAX_REQ-1:0] bus,
        input int i
    );
        return bus[i*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port; one-cycle registered write.
// Define REGFILE_ARB_FORWARD_EN to add the read-address forwarding compare.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      STALL,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [5*NUM_REQ-1:0]      REQ_ADDR,
    input  logic [32*NUM_REQ-1:0]     REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic                      WE,
    output logic [REG_ADDR_W-1:0]     A3,
    output logic [DATA_W-1:0]         WD,
    output logic [ID_W-1:0]           GRANT_ID
`ifdef REGFILE_ARB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]     RD_A1,
    input  logic [REG_ADDR_W-1:0]     RD_A2,
    output logic                      FWD_HIT1,
    output logic                      FWD_HIT2,
    output logic [DATA_W-1:0]         FWD_DATA1,
    output logic [DATA_W-1:0]         FWD_DATA2
`endif
);
    logic [ID_W-1:0]               ptr;
    logic [NUM_REQ-1:0]            grant;
    logic [ID_W-1:0]               grant_idx;
    logic                          any_grant;
    logic                          xfer;
    logic [REG_ADDR_W*MAX_REQ-1:0] addr_ext;
    logic [DATA_W*MAX_REQ-1:0]     data_ext;
    logic [REG_ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]             sel_data;

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req   (REQ_VALID),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_grant)
    );

    assign REQ_READY = (STALL || RESET) ? '0 : grant;
    assign xfer      = any_grant && !STALL && !RESET;
    assign addr_ext  = (REG_ADDR_W*MAX_REQ)'(REQ_ADDR);
    assign data_ext  = (DATA_W*MAX_REQ)'(REQ_DATA);
    assign sel_addr  = addr_slice(addr_ext, int'(grant_idx));
    assign sel_data  = data_slice(data_ext, int'(grant_idx));

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ptr      <= '0;
            WE       <= 1'b0;
            A3       <= '0;
            WD       <= '0;
            GRANT_ID <= '0;
        end else if (xfer) begin
            ptr      <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            GRANT_ID <= grant_idx;
            // Writes to $zero are consumed but never reach the register file.
            if (sel_addr == ZERO_REG) begin
                WE <= 1'b0;
                A3 <= '0;
                WD <= '0;
            end else begin
                WE <= 1'b1;
                A3 <= sel_addr;
                WD <= sel_data;
            end
        end else begin
            WE <= 1'b0;
        end
    end

`ifdef REGFILE_ARB_FORWARD_EN
    assign FWD_HIT1  = WE && (A3 == RD_A1) && (RD_A1 != ZERO_REG);
    assign FWD_HIT2  = WE && (A3 == RD_A2) && (RD_A2 != ZERO_REG);
    assign FWD_DATA1 = WD;
    assign FWD_DATA2 = WD;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter against a round-robin reference model.
module tb_regfile_write_arbiter;
    localparam int N   = 3;
    localparam int IDW = 2;

    logic            CLOCK = 1'b0;
    logic            RESET;
    logic            STALL;
    logic [N-1:0]    REQ_VALID;
    logic [5*N-1:0]  REQ_ADDR;
    logic [32*N-1:0] REQ_DATA;
    logic [N-1:0]    REQ_READY;
    logic            WE;
    logic [4:0]      A3;
    logic [31:0]     WD;
    logic [IDW-1:0]  GRANT_ID;

    regfile_write_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .STALL     (STALL),
        .REQ_VALID (REQ_VALID),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_DATA  (REQ_DATA),
        .REQ_READY (REQ_READY),
        .WE        (WE),
        .A3        (A3),
        .WD        (WD),
        .GRANT_ID  (GRANT_ID)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    bit          pend[N];
    logic [4:0]  p_addr[N];
    logic [31:0] p_data[N];
    int          m_ptr;
    exp_t        m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each registered write-port state is compared one edge after it was predicted.
    initial begin
        forever begin
            exp_t e;
            @(posedge CLOCK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("we", 32'(WE), 32'(e.we));
                chk("a3", 32'(A3), 32'(e.a3));
                chk("wd", WD, e.wd);
                chk("grant_id", 32'(GRANT_ID), 32'(e.id));
            end
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            REQ_VALID[i]          = pend[i];
            REQ_ADDR[5*i +: 5]    = p_addr[i];
            REQ_DATA[32*i +: 32]  = p_data[i];
        end
    endtask

    task automatic cycle(input int pv, input int ps, input logic [N-1:0] mask, input bit directed);
        int win;
        logic [N-1:0] exp_ready;
        @(negedge CLOCK);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && ($urandom_range(99) < pv)) begin
                pend[i] = 1'b1;
                if (directed) begin
                    p_addr[i] = 5'(i + 1);
                    p_data[i] = 32'h11 * (i + 1);
                end else begin
                    p_addr[i] = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                    p_data[i] = $urandom;
                end
            end
        end
        STALL = ($urandom_range(99) < ps);
        drive_reqs();
        #1;
        win = -1;
        if (!STALL)
            for (int k = 0; k < N; k++)
                if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(REQ_READY), 32'(exp_ready));
        if (win >= 0) begin
            m_ptr    = (win + 1) % N;
            m_out.id = win;
            if (p_addr[win] == 5'd0) begin
                m_out.we = 1'b0;
                m_out.a3 = 5'd0;
                m_out.wd = 32'd0;
            end else begin
                m_out.we = 1'b1;
                m_out.a3 = p_addr[win];
                m_out.wd = p_data[win];
            end
            pend[win] = 1'b0;
        end else begin
            m_out.we = 1'b0;
        end
        q.push_back(m_out);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(WE), 32'd0);
        chk({tag, "_a3"}, 32'(A3), 32'd0);
        chk({tag, "_wd"}, WD, 32'd0);
        chk({tag, "_gid"}, 32'(GRANT_ID), 32'd0);
        chk({tag, "_ready"}, 32'(REQ_READY), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check_reset_state("midrst");
        q.delete();
        @(negedge CLOCK);
        STALL = 1'b1;
        RESET = 1'b0;
        m_ptr = 0;
        m_out = '{1'b0, 5'd0, 32'd0, 0};
        #1;
        chk("post_rst_stall_ready", 32'(REQ_READY), 32'd0);
    endtask

    initial begin
        RESET = 1'b1;
        STALL = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b1;
            p_addr[i] = 5'(i + 1);
            p_data[i] = 32'h11 * (i + 1);
        end
        drive_reqs();
        m_ptr = 0;
        m_out = '{1'b0, 5'd0, 32'd0, 0};
        #3;
        check_reset_state("rst");
        @(negedge CLOCK);
        RESET = 1'b0;
        STALL = 1'b1;

        repeat (12) cycle(100, 0, '1, 1'b1);
        repeat (4)  cycle(0, 0, '1, 1'b0);
        repeat (20) cycle(100, 50, 3'b010, 1'b0);
        repeat (20) cycle(100, 0, 3'b101, 1'b0);
        repeat (300) cycle(60, 20, '1, 1'b0);
        repeat (5)  cycle(100, 0, '1, 1'b1);
        mid_reset();
        repeat (200) cycle(70, 15, '1, 1'b0);
        repeat (6)  cycle(0, 0, '1, 1'b0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (WE/A3/WD) among NUM_REQ writeback requesters, e.g. ALU writeback, load unit and multiply/divide unit.
- Uses round-robin arbitration with a valid/ready handshake, at most one grant per cycle.
- The winning write is registered on posedge CLOCK, so WE/A3/WD are stable when the register file samples them on the following negedge.
- Sits between the writeback stage and the register file.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 2, width of GRANT_ID; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  pipeline hold; blocks all grants while high.
- REQ_VALID  in  NUM_REQ  per-requester write request.
- REQ_ADDR  in  5*NUM_REQ  flattened destination register numbers; requester i uses bits [5i+4:5i].
- REQ_DATA  in  32*NUM_REQ  flattened write data; requester i uses bits [32i+31:32i].
- REQ_READY  out  NUM_REQ  combinational grant, one-hot or zero.
- WE  out  1  register-file write enable (registered).
- A3  out  5  register-file write address (registered).
- WD  out  32  register-file write data (registered).
- GRANT_ID  out  ID_W  index of the requester whose write is on WE/A3/WD (registered).

Behaviour:
- Reset: CLOCK is the single clock; RESET is asynchronous and active-high. While RESET is high:
  - WE=0, A3=0, WD=0, GRANT_ID=0, round-robin pointer PTR=0.
  - REQ_READY=0 regardless of other inputs.
- Grant selection, combinational: if STALL=0, search REQ_VALID starting at index PTR, ascending with wrap-around modulo NUM_REQ. The first set bit i wins and REQ_READY[i]=1; all other REQ_READY bits are 0.
- Transfer: occurs at posedge CLOCK when REQ_VALID[i] & REQ_READY[i]. The requester holds VALID/ADDR/DATA stable until the transfer; it must not drop VALID before then.
- Latency: the transfer at edge N drives WE=1, A3=REQ_ADDR[i], WD=REQ_DATA[i], GRANT_ID=i during cycle N..N+1. The register file commits the write at the negedge within that cycle. One-cycle latency.
- No transfer at an edge (no valid requester, or STALL=1): WE=0 next cycle. A3, WD and GRANT_ID hold their previous values.
- Pointer update: on a transfer, PTR <= (i+1) mod NUM_REQ. Otherwise PTR holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of STALL being low.
- $zero writes: a grant with REQ_ADDR=0 is handshaked normally (READY=1, PTR advances), but the next cycle has WE=0, A3=0, WD=0. Register 0 is never written.
- STALL:
  - STALL=1 forces REQ_READY=0 combinationally in the same cycle.
  - A write already registered on WE still completes; it is not cancelled.
- Reset mid-operation: any pending registered write is discarded and WE drops immediately (asynchronous). Requests still valid after reset release are re-arbitrated from PTR=0.
- Single requester: always granted while valid and STALL=0, so back-to-back writes give 100% WE duty.
- Width rules: PTR is ID_W bits. Wrap-around uses an explicit compare with NUM_REQ-1, not a power-of-2 overflow.

Optional Feature:
- REGFILE_ARB_FORWARD_EN defined adds these ports:
  - RD_A1, RD_A2  in  5  read addresses.
  - FWD_HIT1, FWD_HIT2  out  1  forwarding hit flags.
  - FWD_DATA1, FWD_DATA2  out  32  forwarded data.
- With it: FWD_HITk = WE & (A3 == RD_Ak) & (RD_Ak != 0), combinational, and FWD_DATAk = WD. This covers reads that sample before the negedge commit.
- Without it: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=5'd0.
  - Function to extract a slice from a flattened request bus.
- Sub-module rr_priority_picker: combinational, parameter NUM_REQ.
  - Inputs: request vector and PTR.
  - Outputs: one-hot grant vector, granted index, any-grant flag.
- The top level holds PTR, the output registers and the optional forwarding compare.

Test Plan:
- Reset: assert RESET mid-cycle with WE=1 -> WE, A3, WD, GRANT_ID drop to 0 immediately; after release, REQ_VALID=3'b111 -> first grant goes to requester 0.
- Round-robin: REQ_VALID=3'b111 held for 6 cycles, data 0x11/0x22/0x33 to regs 1/2/3 -> GRANT_ID sequence 0,1,2,0,1,2; WE=1 every cycle; A3/WD match per requester one cycle after each grant.
- Pointer skip: PTR=1, REQ_VALID=3'b001 -> requester 0 granted; next cycle PTR=1; then REQ_VALID=3'b101 -> requester 2 granted.
- $zero: requester 1 writes addr 0, data 0xDEADBEEF -> REQ_READY[1]=1, next cycle WE=0, A3=0, WD=0; next grant starts search at index 2.
- Stall: assert STALL for 3 cycles with REQ_VALID=3'b010 -> REQ_READY=0 and WE=0 for those cycles (after one in-flight write completes); first cycle after STALL drops -> grant to requester 1.
- Forwarding (macro on): WE=1, A3=5, WD=0x1234; RD_A1=5, RD_A2=0 -> FWD_HIT1=1, FWD_DATA1=0x1234, FWD_HIT2=0.
